// File: rtl/sar_sequencer.sv
// sar_sequencer -- timing controller for the SAR conversion loop.
//
// Generates the seq_init / seq_comp / seq_update strobe sequence that drives
// the SAR register and comparator for a programmable number of bit cycles,
// then captures the SAR register value as the conversion result.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst_n        synchronous, active-low reset
//   start        conversion request, sampled only in IDLE
//   abort        synchronous cancel of a running conversion
//   cfg_tinit    seq_init high time in clk cycles (0 treated as 1)
//   cfg_tcomp    seq_comp high time in clk cycles (0 treated as 1)
//   cfg_tupd     seq_update high time in clk cycles (0 treated as 1)
//   cfg_ncycles  bit cycles per conversion (0 or > NBITS treated as NBITS)
//   dac_state    current SAR register value
//   seq_init     init strobe to the SAR logic
//   seq_comp     comparator strobe
//   seq_update   update strobe to the SAR logic
//   busy         conversion in progress
//   done         one-cycle pulse, result valid
//   result       captured conversion value
module sar_sequencer #(
  parameter int NBITS = 16,
  parameter int CYCW  = 8,
  parameter int CNTW  = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CYCW-1:0]  cfg_tinit,
  input  logic [CYCW-1:0]  cfg_tcomp,
  input  logic [CYCW-1:0]  cfg_tupd,
  input  logic [CNTW-1:0]  cfg_ncycles,
  input  logic [NBITS-1:0] dac_state,
  output logic             seq_init,
  output logic             seq_comp,
  output logic             seq_update,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    COMP = 2'd2,
    UPD  = 2'd3
  } state_t;

  state_t state, next_state;

  // Phase counter counts down to 0; it holds (duration - 1) at phase entry.
  logic [CYCW-1:0] phase_cnt;
  logic [CNTW-1:0] bit_cnt;

  // Latched, already-clamped configuration of the running conversion.
  logic [CYCW-1:0] tcomp_m1;
  logic [CYCW-1:0] tupd_m1;
  logic [CNTW-1:0] n_lat;

  logic accept;
  logic phase_last;
  logic bit_last;
  logic complete;

  // Duration field to reload value; a zero duration behaves as one cycle.
  function automatic logic [CYCW-1:0] dur_m1(input logic [CYCW-1:0] d);
    return (d == '0) ? '0 : d - CYCW'(1);
  endfunction

  assign accept     = (state == IDLE) && start && !abort;
  assign phase_last = (phase_cnt == '0);
  assign bit_last   = ((bit_cnt + CNTW'(1)) == n_lat);
  assign complete   = (state == UPD) && phase_last && bit_last && !abort;

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (!rst_n) begin
      // NOTE: the latched config is reset too, even though it is always
      // rewritten before use, so no X ever leaks out of a fresh reset.
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      tcomp_m1  <= '0;
      tupd_m1   <= '0;
      n_lat     <= '0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state <= next_state;
      done  <= complete;
      if (complete) begin
        result <= dac_state;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            tcomp_m1  <= dur_m1(cfg_tcomp);
            tupd_m1   <= dur_m1(cfg_tupd);
            n_lat     <= (cfg_ncycles == '0 || cfg_ncycles > CNTW'(NBITS))
                         ? CNTW'(NBITS) : cfg_ncycles;
            phase_cnt <= dur_m1(cfg_tinit);
            bit_cnt   <= '0;
          end
        end
        INIT: phase_cnt <= phase_last ? tcomp_m1 : phase_cnt - CYCW'(1);
        COMP: phase_cnt <= phase_last ? tupd_m1  : phase_cnt - CYCW'(1);
        UPD: begin
          if (phase_last) begin
            bit_cnt   <= bit_cnt + CNTW'(1);
            phase_cnt <= tcomp_m1;
          end else begin
            phase_cnt <= phase_cnt - CYCW'(1);
          end
        end
        default: phase_cnt <= '0;
      endcase
    end
  end

  // Next-state logic; abort returns any busy state to IDLE.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = INIT;
      INIT: begin
        if (abort)           next_state = IDLE;
        else if (phase_last) next_state = COMP;
      end
      COMP: begin
        if (abort)           next_state = IDLE;
        else if (phase_last) next_state = UPD;
      end
      UPD: begin
        if (abort)           next_state = IDLE;
        else if (phase_last) next_state = bit_last ? IDLE : COMP;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode from the state register only, so at most one strobe is
  // high and phases abut with no gap cycle.
  always_comb begin
    seq_init   = 1'b0;
    seq_comp   = 1'b0;
    seq_update = 1'b0;
    case (state)
      INIT:    seq_init   = 1'b1;
      COMP:    seq_comp   = 1'b1;
      UPD:     seq_update = 1'b1;
      default: ;
    endcase
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_sar_sequencer.sv
// Self-checking bench for sar_sequencer. A reference model expands each
// accepted conversion into a queue of per-cycle strobe phases; every cycle
// the DUT outputs are compared against the head of that queue.
module tb_sar_sequencer;

  localparam int NBITS = 16;
  localparam int CYCW  = 8;
  localparam int CNTW  = $clog2(NBITS + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CYCW-1:0]  cfg_tinit;
  logic [CYCW-1:0]  cfg_tcomp;
  logic [CYCW-1:0]  cfg_tupd;
  logic [CNTW-1:0]  cfg_ncycles;
  logic [NBITS-1:0] dac_state;
  logic             seq_init;
  logic             seq_comp;
  logic             seq_update;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;

  sar_sequencer #(.NBITS(NBITS), .CYCW(CYCW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_tinit   (cfg_tinit),
    .cfg_tcomp   (cfg_tcomp),
    .cfg_tupd    (cfg_tupd),
    .cfg_ncycles (cfg_ncycles),
    .dac_state   (dac_state),
    .seq_init    (seq_init),
    .seq_comp    (seq_comp),
    .seq_update  (seq_update),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Phase codes: 1 = init, 2 = comp, 3 = upd. The queue head is the phase
  // of the current cycle; an empty queue means idle.
  int               sched[$];
  logic             m_done   = 1'b0;
  logic [NBITS-1:0] m_result = '0;

  task automatic model_step();
    int ti, tc, tu, n;
    if (!rst_n) begin
      sched.delete();
      m_done   = 1'b0;
      m_result = '0;
    end else if (sched.size() != 0) begin
      m_done = 1'b0;
      if (abort) sched.delete();
      else begin
        void'(sched.pop_front());
        if (sched.size() == 0) begin
          m_done   = 1'b1;
          m_result = dac_state;
        end
      end
    end else begin
      m_done = 1'b0;
      if (start && !abort) begin
        ti = (cfg_tinit == 0) ? 1 : int'(cfg_tinit);
        tc = (cfg_tcomp == 0) ? 1 : int'(cfg_tcomp);
        tu = (cfg_tupd  == 0) ? 1 : int'(cfg_tupd);
        n  = (cfg_ncycles == 0 || cfg_ncycles > NBITS) ? NBITS : int'(cfg_ncycles);
        repeat (ti) sched.push_back(1);
        repeat (n) begin
          repeat (tc) sched.push_back(2);
          repeat (tu) sched.push_back(3);
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_strobes();
    if (sched.size() == 0) return 3'b000;
    case (sched[0])
      1:       return 3'b100;
      2:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic compare_all();
    check("strobes", {29'd0, seq_init, seq_comp, seq_update}, {29'd0, exp_strobes()});
    check("busy",    {31'd0, busy},   {31'd0, (sched.size() != 0)});
    check("done",    {31'd0, done},   {31'd0, m_done});
    check("result",  {16'd0, result}, {16'd0, m_result});
  endtask

  // One clock: model and DUT see the same inputs at the edge, outputs are
  // compared at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_cfg(input int ti, input int tc, input int tu, input int n);
    cfg_tinit   = CYCW'(ti);
    cfg_tcomp   = CYCW'(tc);
    cfg_tupd    = CYCW'(tu);
    cfg_ncycles = CNTW'(n);
  endtask

  // Start a conversion, scramble cfg afterwards, and measure busy length and
  // update pulse count until done (bounded).
  task automatic run_conv(input string tag, input int exp_busy, input int exp_upd);
    int  bc   = 0;
    int  upds = 0;
    bit  seen = 0;
    logic prev_upd = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 20));
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (busy) bc++;
      if (seq_update && !prev_upd) upds++;
      prev_upd = seq_update;
      if (done) seen = 1;
      else tick();
    end
    check({tag, "_done"}, {31'd0, seen}, 32'd1);
    check({tag, "_busy_len"}, bc, exp_busy);
    check({tag, "_upd_pulses"}, upds, exp_upd);
  endtask

  initial begin
    int ndone;
    int upds;
    logic prev_upd;
    bit b2b_checked;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(1, 1, 1, 16);
    dac_state = '0;
    tick();
    tick();
    check("reset_result", {16'd0, result}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1/1/1, N=16
    set_cfg(1, 1, 1, 16);
    dac_state = 16'hA5C3;
    run_conv("basic", 33, 16);
    check("basic_result", {16'd0, result}, 32'h0000A5C3);

    // 3/2/4, N=4 with cfg scrambled mid-run
    set_cfg(3, 2, 4, 4);
    dac_state = 16'h5A5A;
    run_conv("t324", 27, 4);
    check("t324_result", {16'd0, result}, 32'h00005A5A);

    // Clamping
    set_cfg(0, 0, 0, 0);
    run_conv("zero_cfg", 33, 16);
    set_cfg(0, 0, 0, 20);
    run_conv("n20", 33, 16);

    // start held high, N=2: back-to-back conversions
    set_cfg(1, 1, 1, 2);
    dac_state = 16'h1234;
    start = 1'b1;
    ndone = 0;
    b2b_checked = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      tick();
      if (ndone == 1 && !b2b_checked) begin
        check("b2b_busy_after_done", {31'd0, busy}, 32'd1);
        check("b2b_init_after_done", {31'd0, seq_init}, 32'd1);
        b2b_checked = 1;
      end
      if (done) ndone++;
      if (ndone == 2) start = 1'b0;
    end
    check("b2b_done_count", ndone, 2);
    check("b2b_result", {16'd0, result}, 32'h00001234);

    // Abort on the third update pulse
    set_cfg(1, 1, 1, 8);
    dac_state = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    upds = 0;
    prev_upd = 1'b0;
    for (int i = 0; i < 100 && upds < 3; i++) begin
      tick();
      if (seq_update && !prev_upd) upds++;
      prev_upd = seq_update;
    end
    check("abort_reached_upd3", upds, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_strobes", {29'd0, seq_init, seq_comp, seq_update}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {16'd0, result}, 32'h00001234);

    // abort + start together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {31'd0, busy}, 32'd0);
    tick();

    // Abort on the final UPD cycle
    set_cfg(1, 1, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("final_upd_reached", {31'd0, seq_update}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("final_abort_done", {31'd0, done}, 32'd0);
    check("final_abort_result", {16'd0, result}, 32'h00001234);
    tick();
    check("final_abort_done2", {31'd0, done}, 32'd0);

    // Reset mid-COMP, then release with start high
    set_cfg(2, 5, 1, 4);
    dac_state = 16'h0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("midcomp_reached", {31'd0, seq_comp}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_outputs", {27'd0, seq_init, seq_comp, seq_update, busy, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    rst_n = 1'b1;
    set_cfg(1, 1, 1, 3);
    run_conv("post_rst", 7, 3);
    check("post_rst_result", {16'd0, result}, 32'h00000F0F);

    // Randomized traffic checked cycle-by-cycle against the model
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 40) == 0);
      rst_n     = ($urandom_range(0, 600) != 0);
      dac_state = NBITS'($urandom());
      if ($urandom_range(0, 7) == 0)
        set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 20));
      tick();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
